// File: rtl/lut_sweeper.sv
// Run-time programmable N-input Boolean function: serially loaded truth table,
// registered point evaluation, and a hardware minterm sweep over valid/ready.
module lut_sweeper #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_en,
    input  logic         load_bit,
    input  logic [N-1:0] eval_in,
    output logic         eval_out,
    input  logic         sweep_start,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [N-1:0] m_index,
    output logic         busy,
    output logic         done,
    output logic [N:0]   count
);

    localparam int DEPTH = 1 << N;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [DEPTH-1:0] table_reg, table_next;
    logic [N-1:0]     idx_reg, idx_next;
    logic [N:0]       count_reg, count_next;
    logic             eval_out_reg;

    logic hit;
    logic accept;
    logic advance;

    // Scan-side outputs decode from registers only, so m_valid never depends on m_ready.
    assign hit      = table_reg[idx_reg];
    assign busy     = (state_reg == ST_SCAN);
    assign done     = (state_reg == ST_DONE);
    assign m_valid  = busy & hit;
    assign m_index  = busy ? idx_reg : '0;
    assign count    = count_reg;
    assign eval_out = eval_out_reg;
    assign accept   = m_valid & m_ready;
    assign advance  = busy & (~hit | m_ready);

    always_comb begin
        state_next = state_reg;
        table_next = table_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        case (state_reg)
            ST_IDLE: begin
                // A start in the same cycle as a load wins; the load is dropped.
                if (sweep_start) begin
                    state_next = ST_SCAN;
                    idx_next   = '0;
                    count_next = '0;
                end else if (load_en) begin
                    table_next = {table_reg[DEPTH-2:0], load_bit};
                end
            end
            ST_SCAN: begin
                if (accept) begin
                    count_next = count_reg + 1'b1;
                end
                if (advance) begin
                    if (idx_reg == N'(DEPTH - 1)) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            table_reg    <= '0;
            idx_reg      <= '0;
            count_reg    <= '0;
            eval_out_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            table_reg    <= table_next;
            idx_reg      <= idx_next;
            count_reg    <= count_next;
            // Reads the pre-load table value when a load lands on the same edge.
            eval_out_reg <= table_reg[eval_in];
        end
    end

endmodule
